// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the serial vector execution sequencer.
//   op_t     - operation encoding (VADD, VDOT, SMUL, reserved)
//   state_t  - sequencer FSM states
//   MAXW     - width of the intermediate exact-result bus used by the helpers
//   vec_fits - 1 when a signed value is representable in dw signed bits
//   vec_reduce - clamp (sat=1) or pass through (sat=0, caller keeps low dw bits)
package vec_pkg;

  typedef enum logic [1:0] {
    OP_VADD = 2'b00,
    OP_VDOT = 2'b01,
    OP_SMUL = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Wide enough for a 2*DW product or the VDOT accumulator at any sane DW.
  localparam int MAXW = 128;

  function automatic logic vec_fits(input logic signed [MAXW-1:0] x, input int dw);
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi = (MAXW'(1) <<< (dw - 1)) - MAXW'(1);
    lo = -hi - MAXW'(1);
    return (x <= hi) && (x >= lo);
  endfunction

  // Wrap is implicit: the caller truncates the returned value to dw bits.
  function automatic logic [MAXW-1:0] vec_reduce(input logic signed [MAXW-1:0] x,
                                                 input int dw, input logic sat);
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi = (MAXW'(1) <<< (dw - 1)) - MAXW'(1);
    lo = -hi - MAXW'(1);
    if (!sat || vec_fits(x, dw)) return x;
    else if (x[MAXW-1]) return lo;
    else return hi;
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// vec_lane_alu: one combinational datapath lane.
//   op     in  operation (VADD uses a+b, SMUL uses a*scalar, VDOT uses a*b)
//   a, b   in  DW-bit signed operands
//   scalar in  DW-bit signed SMUL multiplier
//   res    out DW-bit result after saturate/wrap
//   ovf    out exact result does not fit in DW signed bits
//   prod   out full 2*DW-bit signed product (feeds the VDOT adder tree)
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int DW  = 16,
  parameter int SAT = 1
) (
  input  op_t                    op,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  input  logic signed [DW-1:0]   scalar,
  output logic [DW-1:0]          res,
  output logic                   ovf,
  output logic signed [2*DW-1:0] prod
);

  logic signed [DW-1:0]   mul_b;
  logic signed [DW:0]     sum;
  logic signed [MAXW-1:0] exact;

  always_comb begin
    mul_b = (op == OP_SMUL) ? scalar : b;
    prod  = (2*DW)'(a) * (2*DW)'(mul_b);
    sum   = (DW+1)'(a) + (DW+1)'(b);
    exact = (op == OP_VADD) ? MAXW'(sum) : MAXW'(prod);
    ovf   = !vec_fits(exact, DW);
    res   = DW'(vec_reduce(exact, DW, SAT != 0));
  end

endmodule

// File: rtl/vec_exec_seq.sv
// vec_exec_seq: serial vector execution sequencer.
//   Clk1, Reset        clock (rising edge) and synchronous active-high reset
//   start, op, scalar  operation request, accepted only while idle
//   busy, done, V      status: in progress, one-cycle completion, sticky overflow
//   rd_en, rd_idx      operand beat read request (data returns next cycle)
//   a_data, b_data     operand beats, lane i at [i*DW +: DW]
//   wr_en, wr_idx, wr_data  vector result beat write (VADD, SMUL)
//   s_wr, s_data       scalar result write (VDOT)
// Pipeline: read request (cycle k+1) -> operand valid (k+2) -> registered result (k+3).
module vec_exec_seq
  import vec_pkg::*;
#(
  parameter  int DW    = 16,
  parameter  int VLEN  = 16,
  parameter  int LANES = 1,
  parameter  int SAT   = 1,
  localparam int N     = VLEN / LANES,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                Clk1,
  input  logic                Reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DW-1:0]       scalar,
  output logic                busy,
  output logic                done,
  output logic                V,
  output logic                rd_en,
  output logic [IW-1:0]       rd_idx,
  input  logic [LANES*DW-1:0] a_data,
  input  logic [LANES*DW-1:0] b_data,
  output logic                wr_en,
  output logic [IW-1:0]       wr_idx,
  output logic [LANES*DW-1:0] wr_data,
  output logic                s_wr,
  output logic [DW-1:0]       s_data
);

  localparam int AW = 2*DW + $clog2(VLEN) + 1;

  state_t        state_reg, state_next;
  logic [IW-1:0] cnt_reg, cnt_next;
  logic          drain_reg, drain_next;
  op_t           op_reg;
  logic [DW-1:0] scalar_reg;
  logic          accept;

  // Datapath pipeline registers
  logic                vld_reg;
  logic [IW-1:0]       vidx_reg;
  logic                wr_en_reg;
  logic [IW-1:0]       wr_idx_reg;
  logic [LANES*DW-1:0] wr_data_reg;
  logic                s_wr_reg;
  logic [DW-1:0]       s_data_reg;
  logic                v_reg;
  logic signed [AW-1:0] acc_reg;

  logic [LANES*DW-1:0]   lane_res;
  logic [LANES-1:0]      lane_ovf;
  logic signed [2*DW-1:0] lane_prod [LANES];
  logic signed [AW-1:0]  prod_sum;
  logic signed [MAXW-1:0] dot_ext;
  logic                  dot_ovf;
  logic [DW-1:0]         dot_res;
  logic                  is_vec;

  assign accept = (state_reg == ST_IDLE) && start;
  assign is_vec = (op_reg != OP_VDOT);

  // FSM: state register
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      drain_reg  <= 1'b0;
      op_reg     <= OP_VADD;
      scalar_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      drain_reg <= drain_next;
      if (accept) begin
        op_reg     <= op_t'(op);
        scalar_reg <= scalar;
      end
    end
  end

  // FSM: next state. DRAIN holds two cycles while the last beat leaves the pipeline.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    drain_next = drain_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (op_t'(op) == OP_RSVD) ? ST_DONE : ST_READ;
          cnt_next   = '0;
        end
      end
      ST_READ: begin
        if (cnt_reg == IW'(N - 1)) begin
          state_next = ST_DRAIN;
          drain_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + IW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_reg) state_next = ST_DONE;
        else           drain_next = 1'b1;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = (state_reg != ST_IDLE);
    done   = (state_reg == ST_DONE);
    rd_en  = (state_reg == ST_READ);
    rd_idx = (state_reg == ST_READ) ? cnt_reg : '0;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    vec_lane_alu #(
      .DW  (DW),
      .SAT (SAT)
    ) u_alu (
      .op     (op_reg),
      .a      (a_data[gi*DW +: DW]),
      .b      (b_data[gi*DW +: DW]),
      .scalar (scalar_reg),
      .res    (lane_res[gi*DW +: DW]),
      .ovf    (lane_ovf[gi]),
      .prod   (lane_prod[gi])
    );
  end

  // VDOT lane-product adder tree
  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < LANES; i++) prod_sum = prod_sum + AW'(lane_prod[i]);
  end

  assign dot_ext = MAXW'(acc_reg);
  assign dot_ovf = !vec_fits(dot_ext, DW);
  assign dot_res = DW'(vec_reduce(dot_ext, DW, SAT != 0));

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      vld_reg     <= 1'b0;
      vidx_reg    <= '0;
      wr_en_reg   <= 1'b0;
      wr_idx_reg  <= '0;
      wr_data_reg <= '0;
      s_wr_reg    <= 1'b0;
      s_data_reg  <= '0;
      v_reg       <= 1'b0;
      acc_reg     <= '0;
    end else begin
      vld_reg   <= rd_en;
      vidx_reg  <= rd_idx;
      wr_en_reg <= vld_reg && is_vec;
      s_wr_reg  <= 1'b0;
      if (accept) begin
        v_reg   <= 1'b0;
        acc_reg <= '0;
      end
      if (vld_reg) begin
        if (is_vec) begin
          wr_idx_reg  <= vidx_reg;
          wr_data_reg <= lane_res;
          if (|lane_ovf) v_reg <= 1'b1;
        end else begin
          acc_reg <= acc_reg + prod_sum;
        end
      end
      // Accumulator is final in the second DRAIN cycle; result lands with done.
      if ((state_reg == ST_DRAIN) && drain_reg && (op_reg == OP_VDOT)) begin
        s_wr_reg   <= 1'b1;
        s_data_reg <= dot_res;
        if (dot_ovf) v_reg <= 1'b1;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_idx  = wr_idx_reg;
  assign wr_data = wr_data_reg;
  assign s_wr    = s_wr_reg;
  assign s_data  = s_data_reg;
  assign V       = v_reg;

endmodule

// File: tb/tb_vec_exec_seq.sv
// tb_vec_exec_seq: drives two sequencer instances (LANES=1/SAT=1 and LANES=4/SAT=0)
// against an element-level arithmetic model and a cycle timeline.
module tb_vec_exec_seq;

  localparam int DW   = 16;
  localparam int VLEN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1;
  logic [1:0]  op;
  logic [15:0] scalar;

  logic        busy0, done0, v0, rd_en0, wr_en0, s_wr0;
  logic [3:0]  rd_idx0, wr_idx0;
  logic [15:0] a0, b0, wr_data0, s_data0;

  logic        busy1, done1, v1, rd_en1, wr_en1, s_wr1;
  logic [1:0]  rd_idx1, wr_idx1;
  logic [63:0] a1, b1, wr_data1;
  logic [15:0] s_data1;

  logic signed [15:0] mem_a [VLEN];
  logic signed [15:0] mem_b [VLEN];

  int checks = 0;
  int errors = 0;

  vec_exec_seq #(.DW(16), .VLEN(16), .LANES(1), .SAT(1)) u_dut0 (
    .Clk1(clk), .Reset(rst), .start(start0), .op(op), .scalar(scalar),
    .busy(busy0), .done(done0), .V(v0), .rd_en(rd_en0), .rd_idx(rd_idx0),
    .a_data(a0), .b_data(b0), .wr_en(wr_en0), .wr_idx(wr_idx0), .wr_data(wr_data0),
    .s_wr(s_wr0), .s_data(s_data0)
  );

  vec_exec_seq #(.DW(16), .VLEN(16), .LANES(4), .SAT(0)) u_dut1 (
    .Clk1(clk), .Reset(rst), .start(start1), .op(op), .scalar(scalar),
    .busy(busy1), .done(done1), .V(v1), .rd_en(rd_en1), .rd_idx(rd_idx1),
    .a_data(a1), .b_data(b1), .wr_en(wr_en1), .wr_idx(wr_idx1), .wr_data(wr_data1),
    .s_wr(s_wr1), .s_data(s_data1)
  );

  // Synchronous register file read ports
  always @(posedge clk) begin
    if (rd_en0) begin
      a0 <= mem_a[rd_idx0];
      b0 <= mem_b[rd_idx0];
    end
    if (rd_en1) begin
      for (int i = 0; i < 4; i++) begin
        a1[i*16 +: 16] <= mem_a[rd_idx1*4 + i];
        b1[i*16 +: 16] <= mem_b[rd_idx1*4 + i];
      end
    end
  end

  typedef struct {
    logic busy, done, v, rd_en, wr_en, s_wr;
    int rd_idx, wr_idx;
    logic [63:0] wr_data;
    logic [15:0] s_data;
  } samp_t;

  samp_t trace [24];

  function automatic samp_t sample(input int sel);
    samp_t s;
    if (sel == 0) begin
      s.busy = busy0; s.done = done0; s.v = v0; s.rd_en = rd_en0; s.wr_en = wr_en0;
      s.s_wr = s_wr0; s.rd_idx = int'(rd_idx0); s.wr_idx = int'(wr_idx0);
      s.wr_data = {48'd0, wr_data0}; s.s_data = s_data0;
    end else begin
      s.busy = busy1; s.done = done1; s.v = v1; s.rd_en = rd_en1; s.wr_en = wr_en1;
      s.s_wr = s_wr1; s.rd_idx = int'(rd_idx1); s.wr_idx = int'(wr_idx1);
      s.wr_data = wr_data1; s.s_data = s_data1;
    end
    return s;
  endfunction

  // Exact element result, then clamp or wrap to 16 bits.
  function automatic logic [15:0] ref_elem(input int o, input longint a, input longint b,
                                           input longint s, input bit sat, output bit ovf);
    longint x;
    x = (o == 0) ? a + b : a * s;
    ovf = (x > 32767) || (x < -32768);
    if (ovf && sat) return (x > 0) ? 16'h7FFF : 16'h8000;
    return 16'(x);
  endfunction

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic fill(input int pat);
    for (int k = 0; k < VLEN; k++) begin
      case (pat)
        0, 1: begin mem_a[k] = 16'(k); mem_b[k] = 16'd100; end
        2: begin mem_a[k] = 16'(k); mem_b[k] = 16'(k + 7); end
        3: begin mem_a[k] = 16'd2; mem_b[k] = 16'(k); end
        4: begin mem_a[k] = 16'd1; mem_b[k] = 16'(k); end
        5: begin mem_a[k] = 16'h7FFF; mem_b[k] = 16'h7FFF; end
        default: begin mem_a[k] = rnd_val(); mem_b[k] = rnd_val(); end
      endcase
    end
    if (pat == 1) begin
      mem_a[5] = 16'h7FFF;
      mem_b[5] = 16'd1;
    end
  endtask

  // Issue one start in cycle 0 and record cycles 1..23 mid-cycle.
  task automatic run_capture(input int sel, input logic [1:0] o, input logic [15:0] s);
    @(negedge clk);
    op = o;
    scalar = s;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int c = 1; c < 24; c++) begin
      trace[c] = sample(sel);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy0, done0, v0, rd_en0, wr_en0, s_wr0} !== 6'b0 || rd_idx0 !== 4'd0 ||
        wr_idx0 !== 4'd0 || wr_data0 !== 16'd0 || s_data0 !== 16'd0) begin
      errors++;
      $display("FAIL reset_dut0: got ctl=%b rd_idx=%0d wr_idx=%0d wr_data=%h s_data=%h, expected all 0",
               {busy0, done0, v0, rd_en0, wr_en0, s_wr0}, rd_idx0, wr_idx0, wr_data0, s_data0);
    end
    checks++;
    if ({busy1, done1, v1, rd_en1, wr_en1, s_wr1} !== 6'b0 || rd_idx1 !== 2'd0 ||
        wr_idx1 !== 2'd0 || wr_data1 !== 64'd0 || s_data1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_dut1: got ctl=%b rd_idx=%0d wr_idx=%0d wr_data=%h s_data=%h, expected all 0",
               {busy1, done1, v1, rd_en1, wr_en1, s_wr1}, rd_idx1, wr_idx1, wr_data1, s_data1);
    end
    $display("txn reset: outputs checked");
    rst = 1'b0;
  endtask

  task automatic test_datapath();
    int sel, o, pat, lanes, nb;
    logic [15:0] scl;
    bit sat, exp_v, ov;
    bit e_busy, e_done, e_rd, e_wr, e_swr;
    logic [15:0] ref_e [VLEN];
    logic [15:0] exp_s;
    logic [63:0] exp_wd;
    longint dot;
    for (int sc = 0; sc < 20; sc++) begin
      scl = 16'd0;
      case (sc)
        0: begin sel = 0; o = 0; pat = 0; end
        1: begin sel = 0; o = 0; pat = 1; end
        2: begin sel = 1; o = 0; pat = 1; end
        3: begin sel = 0; o = 2; pat = 2; scl = 16'hFFFD; end
        4: begin sel = 0; o = 2; pat = 3; scl = 16'h4000; end
        5: begin sel = 0; o = 1; pat = 4; end
        6: begin sel = 0; o = 1; pat = 5; end
        7: begin sel = 1; o = 0; pat = 0; end
        8: begin sel = 1; o = 1; pat = 5; end
        9: begin sel = 1; o = 2; pat = 3; scl = 16'h4000; end
        default: begin
          sel = $urandom_range(0, 1); o = $urandom_range(0, 2); pat = 6; scl = rnd_val();
        end
      endcase
      fill(pat);
      lanes = (sel != 0) ? 4 : 1;
      nb = VLEN / lanes;
      sat = (sel == 0);
      exp_v = 1'b0;
      dot = 0;
      for (int e = 0; e < VLEN; e++) begin
        ref_e[e] = ref_elem(o, mem_a[e], mem_b[e], $signed(scl), sat, ov);
        exp_v |= ov;
        dot += longint'(mem_a[e]) * longint'(mem_b[e]);
      end
      exp_s = 16'd0;
      if (o == 1) begin
        exp_v = (dot > 32767) || (dot < -32768);
        exp_s = (exp_v && sat) ? ((dot > 0) ? 16'h7FFF : 16'h8000) : 16'(dot);
      end
      run_capture(sel, 2'(o), scl);
      for (int c = 1; c <= nb + 4; c++) begin
        e_busy = (c <= nb + 3);
        e_done = (c == nb + 3);
        e_rd   = (c <= nb);
        e_wr   = (o != 1) && (c >= 3) && (c <= nb + 2);
        e_swr  = (o == 1) && (c == nb + 3);
        checks++;
        if ({trace[c].busy, trace[c].done, trace[c].rd_en, trace[c].wr_en, trace[c].s_wr}
            !== {e_busy, e_done, e_rd, e_wr, e_swr}) begin
          errors++;
          $display("FAIL ctrl sc%0d cycle%0d (busy,done,rd,wr,swr): got %b expected %b", sc, c,
                   {trace[c].busy, trace[c].done, trace[c].rd_en, trace[c].wr_en, trace[c].s_wr},
                   {e_busy, e_done, e_rd, e_wr, e_swr});
        end
        if (e_rd) begin
          checks++;
          if (trace[c].rd_idx != c - 1) begin
            errors++;
            $display("FAIL rd_idx sc%0d cycle%0d: got %0d expected %0d", sc, c, trace[c].rd_idx, c - 1);
          end
        end
        if (e_wr) begin
          exp_wd = '0;
          for (int i = 0; i < lanes; i++) exp_wd[i*16 +: 16] = ref_e[(c-3)*lanes + i];
          checks++;
          if (trace[c].wr_idx != c - 3 || trace[c].wr_data !== exp_wd) begin
            errors++;
            $display("FAIL wr sc%0d cycle%0d: got idx %0d data %h expected idx %0d data %h",
                     sc, c, trace[c].wr_idx, trace[c].wr_data, c - 3, exp_wd);
          end
        end
        if (e_swr) begin
          checks++;
          if (trace[c].s_data !== exp_s) begin
            errors++;
            $display("FAIL s_data sc%0d: got %h expected %h", sc, trace[c].s_data, exp_s);
          end
        end
        if (c >= nb + 3) begin
          checks++;
          if (trace[c].v !== exp_v) begin
            errors++;
            $display("FAIL V sc%0d cycle%0d: got %b expected %b", sc, c, trace[c].v, exp_v);
          end
        end
      end
      // Literal values straight from the operation definitions
      case (sc)
        0: begin checks++; if (trace[10].wr_data[15:0] !== 16'd107) begin errors++;
             $display("FAIL vadd_elem7: got %h expected %h", trace[10].wr_data[15:0], 16'd107); end end
        1: begin checks++; if (trace[8].wr_data[15:0] !== 16'h7FFF) begin errors++;
             $display("FAIL vadd_sat: got %h expected 7fff", trace[8].wr_data[15:0]); end end
        2: begin checks++; if (trace[4].wr_data[31:16] !== 16'h8000) begin errors++;
             $display("FAIL vadd_wrap_lane1: got %h expected 8000", trace[4].wr_data[31:16]); end end
        5: begin checks++; if (trace[19].s_data !== 16'd120) begin errors++;
             $display("FAIL vdot_120: got %0d expected 120", trace[19].s_data); end end
        6: begin checks++; if (trace[19].s_data !== 16'h7FFF) begin errors++;
             $display("FAIL vdot_sat: got %h expected 7fff", trace[19].s_data); end end
        default: ;
      endcase
      $display("txn %0d: dut%0d op=%0d scalar=%h V=%0b", sc, sel, o, scl, trace[nb+3].v);
    end
  endtask

  task automatic test_reserved();
    fill(1);
    run_capture(0, 2'b00, 16'd0);
    checks++;
    if (trace[19].v !== 1'b1) begin
      errors++;
      $display("FAIL rsvd_setup_V: got %b expected 1", trace[19].v);
    end
    run_capture(0, 2'b11, 16'd0);
    checks++;
    if ({trace[1].busy, trace[1].done, trace[1].rd_en, trace[1].v} !== 4'b1100) begin
      errors++;
      $display("FAIL rsvd_cycle1 (busy,done,rd,V): got %b expected 1100",
               {trace[1].busy, trace[1].done, trace[1].rd_en, trace[1].v});
    end
    for (int c = 2; c < 8; c++) begin
      checks++;
      if ({trace[c].busy, trace[c].done, trace[c].rd_en, trace[c].wr_en, trace[c].s_wr, trace[c].v} !== 6'b0) begin
        errors++;
        $display("FAIL rsvd_cycle%0d (busy,done,rd,wr,swr,V): got %b expected 000000", c,
                 {trace[c].busy, trace[c].done, trace[c].rd_en, trace[c].wr_en, trace[c].s_wr, trace[c].v});
      end
    end
    $display("txn reserved: dut0 op=3");
  endtask

  task automatic test_start_held();
    fill(0);
    @(negedge clk);
    op = 2'b00;
    start0 = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      checks++;
      if (c <= 19 && busy0 !== 1'b1) begin
        errors++;
        $display("FAIL held_busy cycle%0d: got %b expected 1", c, busy0);
      end else if (c == 20 && (busy0 !== 1'b0 || rd_en0 !== 1'b0)) begin
        errors++;
        $display("FAIL held_gap cycle20: got busy=%b rd_en=%b expected 0 0", busy0, rd_en0);
      end else if (c == 21 && (busy0 !== 1'b1 || rd_en0 !== 1'b1 || rd_idx0 !== 4'd0)) begin
        errors++;
        $display("FAIL held_restart cycle21: got busy=%b rd_en=%b rd_idx=%0d expected 1 1 0",
                 busy0, rd_en0, rd_idx0);
      end else if (c >= 17 && c <= 20 && rd_en0 !== 1'b0) begin
        errors++;
        $display("FAIL held_rd cycle%0d: got rd_en=%b expected 0", c, rd_en0);
      end
    end
    start0 = 1'b0;
    repeat (25) @(negedge clk);
    $display("txn start_held: dut0 VADD");
  endtask

  task automatic test_reset_midop();
    fill(0);
    @(negedge clk);
    op = 2'b00;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (wr_en0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre cycle8: got wr_en=%b busy=%b expected 1 1", wr_en0, busy0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy0, done0, v0, rd_en0, wr_en0, s_wr0} !== 6'b0 || rd_idx0 !== 4'd0 ||
        wr_idx0 !== 4'd0 || wr_data0 !== 16'd0 || s_data0 !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid cycle9: got ctl=%b rd_idx=%0d wr_idx=%0d wr_data=%h s_data=%h expected all 0",
               {busy0, done0, v0, rd_en0, wr_en0, s_wr0}, rd_idx0, wr_idx0, wr_data0, s_data0);
    end
    for (int c = 10; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if ({busy0, rd_en0, wr_en0, s_wr0, done0} !== 5'b0) begin
        errors++;
        $display("FAIL rst_after cycle%0d (busy,rd,wr,swr,done): got %b expected 00000", c,
                 {busy0, rd_en0, wr_en0, s_wr0, done0});
      end
    end
    $display("txn reset_midop: dut0 VADD aborted");
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    op = 2'b00;
    scalar = 16'd0;
    test_reset();
    test_datapath();
    test_reserved();
    test_start_held();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_exec_seq.md
# vec_exec_seq

Parametrised serial vector execution sequencer for the vector datapath. It accepts one vector operation (VADD, VDOT, SMUL), streams operand elements out of the vector register file LANES elements per beat, and writes results back to the vector or scalar register file. It runs single-clock on Clk1 and is intended to replace the per-operation serial units under the core control FSM.

## Interface
- DW, 16: element width in bits, signed two's complement.
- VLEN, 16: elements per vector; must be a multiple of LANES.
- LANES, 1: elements processed per beat; N = VLEN/LANES beats; IW = max(1, clog2(N)).
- SAT, 1: 1 = saturate results on overflow, 0 = wrap (keep low DW bits).

- Clk1  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- start  in  1  operation request; sampled only when busy=0.
- op  in  2  00 VADD, 01 VDOT, 10 SMUL, 11 reserved.
- scalar  in  DW  SMUL multiplier; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- V  out  1  overflow flag of last operation.
- rd_en  out  1  operand read strobe.
- rd_idx  out  IW  beat index of operand read.
- a_data  in  LANES*DW  operand A beat; lane i at [i*DW +: DW].
- b_data  in  LANES*DW  operand B beat; ignored for SMUL.
- wr_en  out  1  vector result write strobe.
- wr_idx  out  IW  beat index of result.
- wr_data  out  LANES*DW  vector result beat.
- s_wr  out  1  scalar result write strobe (VDOT).
- s_data  out  DW  VDOT result.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 latches op and scalar, clears V, enters READ. start is ignored while busy=1.
- READ: rd_en=1 and rd_idx counts 0..N-1, one beat per cycle. After beat N-1 the FSM enters DRAIN.
- DRAIN: lasts 2 cycles, until the last result is written. It then enters DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- op=11: goes straight from IDLE to DONE. No reads or writes occur, and V=0.
- VADD: per lane, a+b.
- SMUL: per lane, a*scalar, full 2DW product.
- Per-lane overflow: the exact result does not fit in DW signed. On overflow:
  - SAT=1 clamps to 2^(DW-1)-1 or -2^(DW-1).
  - SAT=0 keeps the low DW bits.
- VDOT: the exact sum over all lanes and beats of a*b goes into a 2DW+clog2(VLEN)+1 bit accumulator, cleared at start. No vector writes occur. The final value is reduced to DW by the same sat/wrap rule, and V is set if it does not fit.
- V is sticky across the operation: it is the OR of all lane overflows. It is valid from the done cycle and held until the next accepted start.
- Reset mid-operation aborts immediately. No further rd_en, wr_en or s_wr is asserted, and the FSM returns to IDLE.
- Reset value of every output is 0: busy, done, V, rd_en, rd_idx, wr_en, wr_idx, wr_data, s_wr, s_data.

## Timing
- The register file read is synchronous. a_data/b_data for rd_idx=k (presented in cycle t) are valid in cycle t+1.
- start is sampled at edge E0. rd_en is high in cycles 1..N with rd_idx=k in cycle k+1.
- Results are registered. wr_en=1 with wr_idx=k in cycle k+3.
- done, and for VDOT s_wr/s_data, occur in cycle N+3.
- busy=1 in cycles 1..N+3 and 0 again from cycle N+4. The earliest next start is sampled at the end of cycle N+4.
- op=11: busy=1 and done=1 in cycle 1 only.
- wr_en/s_wr are never asserted together with a read of the same index in the same cycle. No hazard handling is required; the caller guarantees register-file ports are free while busy.

## Structure
- vec_pkg holds the op encoding, the state enum, and a saturate/overflow function of width parameters.
- Sub-module vec_lane_alu: one lane, combinational add/mul with overflow flag and SAT clamp. It is instantiated LANES times via generate.
- The VDOT lane-product adder tree plus accumulator stays in vec_exec_seq.

## Test plan
- VADD, defaults:
  - Stimulus: A[k]=k, B[k]=100.
  - Required response: wr_data at wr_idx k = k+100; wr_en in cycles 3..18; done in cycle 19; V=0.
- VADD overflow, SAT=1:
  - Stimulus: A[5]=0x7FFF, B[5]=1.
  - Required response: wr_data[5]=0x7FFF and V=1.
  - With SAT=0: wr_data[5]=0x8000 and V=1.
- SMUL:
  - Stimulus: scalar=-3, A[k]=k.
  - Required response: results -3k, V=0.
  - With scalar=0x4000 and A[k]=2: 0x7FFF, V=1.
- VDOT:
  - Stimulus: A[k]=1, B[k]=k.
  - Required response: s_wr with s_data=120 in cycle 19; no wr_en pulses.
  - With A=B=0x7FFF all elements: s_data=0x7FFF, V=1.
- LANES=4, VLEN=16 VADD:
  - Required response: 4 read beats; done in cycle 7; lane ordering correct.
- Protocol:
  - Stimulus: start held high through a whole operation.
  - Required response: no second operation begins before busy falls.
  - Stimulus: Reset in cycle 8.
  - Required response: all outputs 0 next cycle, no further writes.
  - Stimulus: op=11.
  - Required response: done in cycle 1, no rd_en.
